// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared constants and state encodings for the 2x2 averaging downscaler
package zoom_pkg;

    localparam int SRC_W    = 320;
    localparam int SRC_H    = 240;
    localparam int DST_W    = 160;
    localparam int DST_H    = 120;
    localparam int PIX_W    = 8;
    localparam int ADDR_W   = 17;
    localparam int DST_LAST = DST_W * DST_H - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_RD3,
        ST_LAST,
        ST_WR
    } state_t;

    // Which corner of the 2x2 source block is being addressed
    typedef enum logic [1:0] {
        PH_TL,
        PH_TR,
        PH_BL,
        PH_BR
    } phase_t;

endpackage

// File: rtl/avg_src_addr_gen.sv
// rtl/avg_src_addr_gen.sv - destination coordinate tracker and 2x2 source address mux
module avg_src_addr_gen #(
    parameter int SRC_W  = zoom_pkg::SRC_W,
    parameter int DST_W  = zoom_pkg::DST_W,
    parameter int DST_H  = zoom_pkg::DST_H,
    parameter int ADDR_W = zoom_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              step_i,
    input  zoom_pkg::phase_t  phase_i,
    output logic [ADDR_W-1:0] addr_o
);
    import zoom_pkg::*;

    localparam int DX_W = $clog2(DST_W);
    localparam int DY_W = $clog2(DST_H);

    logic [DX_W-1:0]   dx_q, dx_d;
    logic [DY_W-1:0]   dy_q, dy_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] p;

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q       <= '0;
            dy_q       <= '0;
            row_base_q <= '0;
        end else begin
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            row_base_q <= row_base_d;
        end
    end

    // row_base tracks 2*dy*SRC_W incrementally so no multiplier/divider is needed
    always_comb begin
        dx_d       = dx_q;
        dy_d       = dy_q;
        row_base_d = row_base_q;
        if (clear_i) begin
            dx_d       = '0;
            dy_d       = '0;
            row_base_d = '0;
        end else if (step_i) begin
            if (dx_q == DX_W'(DST_W - 1)) begin
                dx_d = '0;
                if (dy_q == DY_W'(DST_H - 1)) begin
                    dy_d       = '0;
                    row_base_d = '0;
                end else begin
                    dy_d       = dy_q + 1'b1;
                    row_base_d = row_base_q + ADDR_W'(2 * SRC_W);
                end
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
    end

    assign p = row_base_q + ADDR_W'({dx_q, 1'b0});

    always_comb begin
        addr_o = p;
        unique case (phase_i)
            PH_TL:   addr_o = p;
            PH_TR:   addr_o = p + ADDR_W'(1);
            PH_BL:   addr_o = p + ADDR_W'(SRC_W);
            PH_BR:   addr_o = p + ADDR_W'(SRC_W + 1);
            default: addr_o = p;
        endcase
    end

endmodule

// File: rtl/avg_downscale_engine.sv
// rtl/avg_downscale_engine.sv - 2x2 box-average downscale engine: fetch four pixels, write rounded mean
module avg_downscale_engine #(
    parameter int SRC_W  = zoom_pkg::SRC_W,
    parameter int DST_W  = zoom_pkg::DST_W,
    parameter int DST_H  = zoom_pkg::DST_H,
    parameter int PIX_W  = zoom_pkg::PIX_W,
    parameter int ADDR_W = zoom_pkg::ADDR_W,
    parameter bit ROUND  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              processing_in,
    input  logic [ADDR_W-1:0] dst_addr_in,
    output logic              adv_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic [PIX_W-1:0]  src_data_i,
    output logic              dst_we_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [PIX_W-1:0]  dst_data_o,
    output logic              busy_o,
    output logic              done_o
);
    import zoom_pkg::*;

    localparam int                SUM_W    = PIX_W + 2;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DST_W * DST_H - 1);
    localparam logic [SUM_W-1:0]  RND      = ROUND ? SUM_W'(2) : SUM_W'(0);

    state_t            state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [ADDR_W-1:0] dst_idx_q, dst_idx_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              proc_q, proc_d;
    logic [ADDR_W-1:0] gen_addr;
    logic [PIX_W-1:0]  avg;
    logic              reading;
    logic              coord_clear;
    logic              coord_step;
    phase_t            phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sum_q      <= '0;
            dst_idx_q  <= '0;
            src_addr_q <= '0;
            proc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            dst_idx_q  <= dst_idx_d;
            src_addr_q <= src_addr_d;
            proc_q     <= proc_d;
        end
    end

    // Any read phase falls back to IDLE the moment the counter drops its flag
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (processing_in) state_d = ST_RD0;
            ST_RD0:  state_d = processing_in ? ST_RD1  : ST_IDLE;
            ST_RD1:  state_d = processing_in ? ST_RD2  : ST_IDLE;
            ST_RD2:  state_d = processing_in ? ST_RD3  : ST_IDLE;
            ST_RD3:  state_d = processing_in ? ST_LAST : ST_IDLE;
            ST_LAST: state_d = processing_in ? ST_WR   : ST_IDLE;
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reading    = 1'b0;
        phase      = PH_TL;
        adv_o      = 1'b0;
        dst_we_o   = 1'b0;
        dst_addr_o = '0;
        dst_data_o = '0;
        done_o     = 1'b0;
        busy_o     = (state_q != ST_IDLE);
        unique case (state_q)
            ST_RD0: begin reading = 1'b1; phase = PH_TL; end
            ST_RD1: begin reading = 1'b1; phase = PH_TR; end
            ST_RD2: begin reading = 1'b1; phase = PH_BL; end
            ST_RD3: begin reading = 1'b1; phase = PH_BR; end
            ST_WR: begin
                adv_o      = 1'b1;
                dst_we_o   = 1'b1;
                dst_addr_o = dst_idx_q;
                dst_data_o = avg;
                done_o     = (dst_idx_q == IDX_LAST);
            end
            default: ;
        endcase
    end

    // Read data trails its address by one cycle, so RD1..LAST each accumulate the previous fetch
    always_comb begin
        sum_d      = sum_q;
        dst_idx_d  = dst_idx_q;
        src_addr_d = src_addr_q;
        proc_d     = processing_in;
        if (state_q == ST_IDLE && processing_in) dst_idx_d = dst_addr_in;
        unique case (state_q)
            ST_RD0:                          sum_d = '0;
            ST_RD1, ST_RD2, ST_RD3, ST_LAST: sum_d = sum_q + SUM_W'(src_data_i);
            default: ;
        endcase
        if (reading) src_addr_d = gen_addr;
    end

    assign avg         = PIX_W'((sum_q + RND) >> 2);
    assign src_addr_o  = reading ? gen_addr : src_addr_q;
    assign coord_clear = (state_q == ST_IDLE) && processing_in && !proc_q;
    assign coord_step  = (state_q == ST_WR);

    avg_src_addr_gen #(
        .SRC_W  (SRC_W),
        .DST_W  (DST_W),
        .DST_H  (DST_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear_i (coord_clear),
        .step_i  (coord_step),
        .phase_i (phase),
        .addr_o  (gen_addr)
    );

endmodule

// File: tb/tb_avg_downscale_engine.sv
// tb/tb_avg_downscale_engine.sv - randomized self-checking bench for avg_downscale_engine
module tb_avg_downscale_engine;

    localparam int SRC_W     = 320;
    localparam int DST_W     = 160;
    localparam int DST_H     = 8;
    localparam int PIX_W     = 8;
    localparam int ADDR_W    = 17;
    localparam int FRAME_PIX = DST_W * DST_H;
    localparam int SRC_N     = SRC_W * 2 * DST_H;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              processing_in = 1'b0;
    logic [ADDR_W-1:0] dst_addr_in = '0;
    logic              adv_o;
    logic [ADDR_W-1:0] src_addr_o;
    logic [PIX_W-1:0]  src_data_i = '0;
    logic              dst_we_o;
    logic [ADDR_W-1:0] dst_addr_o;
    logic [PIX_W-1:0]  dst_data_o;
    logic              busy_o;
    logic              done_o;

    avg_downscale_engine #(
        .SRC_W  (SRC_W),
        .DST_W  (DST_W),
        .DST_H  (DST_H),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W),
        .ROUND  (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .processing_in (processing_in),
        .dst_addr_in   (dst_addr_in),
        .adv_o         (adv_o),
        .src_addr_o    (src_addr_o),
        .src_data_i    (src_data_i),
        .dst_we_o      (dst_we_o),
        .dst_addr_o    (dst_addr_o),
        .dst_data_o    (dst_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [SRC_N];
    int n_checks = 0;
    int n_errs   = 0;
    int rd_addr  = 0;
    int cnt      = 0;
    int exp_idx  = 0;
    int writes   = 0;
    bit proc     = 1'b0;
    bit kill     = 1'b0;
    int aq[$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [67:0] pack4(input int a, input int b, input int c, input int d);
        return {17'(a), 17'(b), 17'(c), 17'(d)};
    endfunction

    function automatic int base_of(input int idx);
        return 2 * (idx / DST_W) * SRC_W + 2 * (idx % DST_W);
    endfunction

    function automatic logic [67:0] model_addrs(input int idx);
        int b = base_of(idx);
        return pack4(b, b + 1, b + SRC_W, b + SRC_W + 1);
    endfunction

    function automatic int model_avg(input int idx);
        int b = base_of(idx);
        int s = int'(mem[b]) + int'(mem[b + 1]) + int'(mem[b + SRC_W]) + int'(mem[b + SRC_W + 1]);
        return (s + 2) / 4;
    endfunction

    // One clock: sync-RAM model, address log, write scoreboard and address-counter model
    task automatic step_cycle();
        logic [67:0] seen;
        @(negedge clk);
        src_data_i = (rd_addr < SRC_N) ? mem[rd_addr] : 8'h00;
        rd_addr    = int'(src_addr_o);
        if (!busy_o) aq.delete();
        else if (!dst_we_o) aq.push_back(int'(src_addr_o));
        if (dst_we_o || adv_o || done_o) begin
            check_eq("we_adv", {dst_we_o, adv_o}, 2'b11);
            check_eq("dst_addr", dst_addr_o, exp_idx);
            check_eq("dst_data", dst_data_o, model_avg(exp_idx));
            check_eq("done", done_o, exp_idx == FRAME_PIX - 1);
            check_eq("rd_cycles", aq.size(), 5);
            seen = (aq.size() >= 4) ? pack4(aq[0], aq[1], aq[2], aq[3]) : '0;
            check_eq("src_addrs", seen, model_addrs(exp_idx));
            if (exp_idx == 0)   check_eq("pix0_data", dst_data_o, 25);
            if (exp_idx == 5)   check_eq("all255", dst_data_o, 255);
            if (exp_idx == 6)   check_eq("all0", dst_data_o, 0);
            if (exp_idx == 159) check_eq("addr159", seen, pack4(318, 319, 638, 639));
            if (exp_idx == 160) check_eq("addr160", seen, pack4(640, 641, 960, 961));
            if (exp_idx == FRAME_PIX - 1) check_eq("addr_last", seen, pack4(4798, 4799, 5118, 5119));
            aq.delete();
            exp_idx++;
            writes++;
            if (cnt == FRAME_PIX - 1) begin proc = 1'b0; cnt = 0; end
            else cnt++;
        end
        processing_in = proc && !kill;
        dst_addr_in   = ADDR_W'(cnt);
    endtask

    task automatic start_frame();
        proc = 1'b1; kill = 1'b0; cnt = 0; exp_idx = 0; writes = 0;
        aq.delete();
        processing_in = 1'b1;
        dst_addr_in   = '0;
    endtask

    task automatic run_frame();
        int n = 0;
        while ((proc || busy_o) && n < 12000) begin
            step_cycle();
            n++;
        end
        check_eq("frame_end", n < 12000, 1'b1);
        check_eq("frame_writes", writes, FRAME_PIX);
        repeat (4) step_cycle();
        check_eq("idle_after", {busy_o, dst_we_o, adv_o, done_o}, 4'b0);
    endtask

    initial begin
        for (int i = 0; i < SRC_N; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'd10; mem[1] = 8'd20; mem[320] = 8'd41; mem[321] = 8'd30;
        mem[10] = 8'd255; mem[11] = 8'd255; mem[330] = 8'd255; mem[331] = 8'd255;
        mem[12] = 8'd0;   mem[13] = 8'd0;   mem[332] = 8'd0;   mem[333] = 8'd0;

        repeat (3) step_cycle();
        check_eq("reset_outs", {adv_o, dst_we_o, done_o, busy_o, src_addr_o, dst_addr_o, dst_data_o}, '0);
        rst = 1'b0;
        step_cycle();

        // Frame 1: first-pixel addresses, then the whole frame against the model
        start_frame();
        step_cycle(); check_eq("rd0_addr", src_addr_o, 0);
        step_cycle(); check_eq("rd1_addr", src_addr_o, 1);
        step_cycle(); check_eq("rd2_addr", src_addr_o, 320);
        step_cycle(); check_eq("rd3_addr", src_addr_o, 321);
        run_frame();

        // Abort pixel 2 during RD2, then restart a new frame
        start_frame();
        repeat (17) step_cycle();
        check_eq("abort_at_rd2", src_addr_o, 4 + SRC_W);
        kill = 1'b1;
        processing_in = 1'b0;
        step_cycle();
        check_eq("abort_idle", {busy_o, dst_we_o, adv_o}, 3'b0);
        for (int i = 0; i < 3; i++) begin
            step_cycle();
            check_eq("abort_no_wr", {dst_we_o, adv_o}, 2'b0);
        end
        check_eq("abort_writes", writes, 2);
        start_frame();
        step_cycle(); check_eq("restart_addr", src_addr_o, 0);

        // Reset while in LAST, then a clean full frame
        repeat (4) step_cycle();
        rst = 1'b1; proc = 1'b0; cnt = 0;
        processing_in = 1'b0;
        step_cycle();
        check_eq("rst_mid_outs", {adv_o, dst_we_o, done_o, busy_o, src_addr_o, dst_addr_o, dst_data_o}, '0);
        rst = 1'b0;
        step_cycle();
        start_frame();
        run_frame();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
